// File: rtl/instmem_fetch.sv
// Instruction memory with a program-load port and a request/valid/ready fetch port.
// Read data is registered; sequential mode fetches from an internal next-address register that wraps at DEPTH-1.
module instmem_fetch #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter int                DEPTH    = 4096,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_IM,
  input  logic [ADDR_W-1:0] addIM,
  input  logic [DATA_W-1:0] dataIM,
  input  logic              wp_en,
  output logic              wr_err,
  input  logic              fetch_req,
  input  logic              fetch_seq,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              addr_err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   fa;
  logic                fa_ok, ld_ok, wr_en;
  logic [DATA_W-1:0]   rd_word;
  logic [ADDR_W-1:0]   nxt_q, nxt_d;
  logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
  logic [DATA_W-1:0]   inst_out_q, inst_out_d;
  logic                addr_err_q, addr_err_d;
  logic                wr_err_q, wr_err_d;

  // Address decode and range checks are done one bit wider so DEPTH == 2**ADDR_W works.
  always_comb begin
    fa       = fetch_seq ? nxt_q : fetch_addr;
    fa_ok    = ({1'b0, fa} < DEPTH_X);
    ld_ok    = ({1'b0, addIM} < DEPTH_X);
    wr_en    = we_IM & ~wp_en & ld_ok;
    wr_err_d = we_IM & (wp_en | ~ld_ok);
  end

  // Memory contents are deliberately outside the reset domain so a program survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addIM[IDX_W-1:0]] <= dataIM;
  end

  // Write-first bypass: a permitted load to the fetched address is forwarded.
  always_comb begin
    rd_word = mem[fa[IDX_W-1:0]];
    if (wr_en && (addIM == fa)) rd_word = dataIM;
    if (!fa_ok)                 rd_word = NOP_WORD;
  end

  always_comb begin
    state_d     = state_q;
    fetch_gnt   = 1'b0;
    inst_out_d  = inst_out_q;
    inst_addr_d = inst_addr_q;
    addr_err_d  = addr_err_q;
    nxt_d       = nxt_q;
    case (state_q)
      EMPTY:   fetch_gnt = fetch_req;
      FULL:    fetch_gnt = fetch_req & inst_ready;
      default: fetch_gnt = 1'b0;
    endcase
    if (fetch_gnt) begin
      state_d     = FULL;
      inst_out_d  = rd_word;
      inst_addr_d = fa;
      addr_err_d  = ~fa_ok;
      nxt_d       = (!fa_ok || ({1'b0, fa} == LAST_X)) ? '0 : fa + ADDR_W'(1);
    end else if ((state_q == FULL) && inst_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      inst_out_q  <= '0;
      inst_addr_q <= '0;
      addr_err_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      nxt_q       <= '0;
    end else begin
      state_q     <= state_d;
      inst_out_q  <= inst_out_d;
      inst_addr_q <= inst_addr_d;
      addr_err_q  <= addr_err_d;
      wr_err_q    <= wr_err_d;
      nxt_q       <= nxt_d;
    end
  end

  assign inst_out   = inst_out_q;
  assign inst_addr  = inst_addr_q;
  assign addr_err   = addr_err_q;
  assign wr_err     = wr_err_q;
  assign inst_valid = (state_q == FULL);

endmodule

// File: tb/tb_instmem_fetch.sv
// Scoreboard bench for instmem_fetch (DEPTH=8, ADDR_W=4): stimulus pushes expected words,
// a negedge monitor pops and compares each word the consumer accepts.
module tb_instmem_fetch;
  localparam int          DW  = 16;
  localparam int          AW  = 4;
  localparam logic [15:0] NOP = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we_IM;
  logic [AW-1:0] addIM;
  logic [DW-1:0] dataIM;
  logic          wp_en;
  logic          wr_err;
  logic          fetch_req, fetch_seq;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_addr;
  logic          inst_valid, inst_ready, addr_err;

  instmem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .we_IM(we_IM), .addIM(addIM), .dataIM(dataIM),
    .wp_en(wp_en), .wr_err(wr_err), .fetch_req(fetch_req), .fetch_seq(fetch_seq),
    .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .inst_out(inst_out),
    .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", {16'h0, inst_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("word_data", {16'h0, inst_out}, {16'h0, e.d});
        chk("word_addr", {28'h0, inst_addr}, {28'h0, e.a});
        chk("word_err",  {31'h0, addr_err}, {31'h0, e.e});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic e);
    exp_t x;
    x.d = d; x.a = a; x.e = e;
    q.push_back(x);
  endtask

  // One load cycle; wr_err is checked in the following cycle.
  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wp,
                      input logic exp_err);
    we_IM = 1'b1; addIM = a; dataIM = d; wp_en = wp;
    cyc();
    we_IM = 1'b0; wp_en = 1'b0;
    chk("wr_err", {31'h0, wr_err}, {31'h0, exp_err});
  endtask

  // Set up a fetch request, check grant, and push the expected word if granted.
  task automatic fetch(input logic seq, input logic [AW-1:0] a, input logic rdy,
                       input logic exp_gnt, input logic [DW-1:0] ed,
                       input logic [AW-1:0] ea, input logic ee);
    fetch_req = 1'b1; fetch_seq = seq; fetch_addr = a; inst_ready = rdy;
    #1;
    chk("fetch_gnt", {31'h0, fetch_gnt}, {31'h0, exp_gnt});
    if (exp_gnt) push(ed, ea, ee);
  endtask

  task automatic drain();
    fetch_req = 1'b0; inst_ready = 1'b1;
    cyc(); cyc();
  endtask

  initial begin
    rst_n = 1'b0; we_IM = 1'b0; addIM = '0; dataIM = '0; wp_en = 1'b0;
    fetch_req = 1'b0; fetch_seq = 1'b0; fetch_addr = '0; inst_ready = 1'b0;
    cyc(); cyc();
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_out",   {16'h0, inst_out},   32'h0);
    chk("rst_addr",  {28'h0, inst_addr},  32'h0);
    chk("rst_aerr",  {31'h0, addr_err},   32'h0);
    chk("rst_werr",  {31'h0, wr_err},     32'h0);
    rst_n = 1'b1;
    cyc();

    load(4'h0, 16'h0234, 1'b0, 1'b0);
    load(4'h1, 16'h0381, 1'b0, 1'b0);
    load(4'h6, 16'h6666, 1'b0, 1'b0);
    load(4'h7, 16'h7777, 1'b0, 1'b0);

    // Sequential fetch from reset value of the next-address register.
    fetch(1'b1, 4'h0, 1'b1, 1'b1, 16'h0234, 4'h0, 1'b0);
    cyc();
    fetch(1'b1, 4'h0, 1'b1, 1'b1, 16'h0381, 4'h1, 1'b0);
    cyc();
    drain();

    // Backpressure: first word held for 5 cycles, second granted once ready rises.
    fetch(1'b0, 4'h0, 1'b0, 1'b1, 16'h0234, 4'h0, 1'b0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      fetch(1'b0, 4'h1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
      chk("bp_valid", {31'h0, inst_valid}, 32'h1);
      chk("bp_out",   {16'h0, inst_out},   32'h0234);
      cyc();
    end
    fetch(1'b0, 4'h1, 1'b1, 1'b1, 16'h0381, 4'h1, 1'b0);
    cyc();
    drain();

    // Write-protect: rejected load pulses wr_err once and leaves memory intact.
    load(4'h0, 16'hFFFF, 1'b1, 1'b1);
    cyc();
    chk("wr_err_pulse_end", {31'h0, wr_err}, 32'h0);
    fetch(1'b0, 4'h0, 1'b1, 1'b1, 16'h0234, 4'h0, 1'b0);
    cyc();
    drain();

    // Collision: permitted load forwards new data; protected load does not.
    we_IM = 1'b1; addIM = 4'h5; dataIM = 16'hABCD; wp_en = 1'b0;
    fetch(1'b0, 4'h5, 1'b1, 1'b1, 16'hABCD, 4'h5, 1'b0);
    cyc();
    we_IM = 1'b0;
    drain();
    we_IM = 1'b1; addIM = 4'h5; dataIM = 16'h1111; wp_en = 1'b1;
    fetch(1'b0, 4'h5, 1'b1, 1'b1, 16'hABCD, 4'h5, 1'b0);
    cyc();
    we_IM = 1'b0; wp_en = 1'b0;
    chk("coll_wr_err", {31'h0, wr_err}, 32'h1);
    drain();

    // Wrap at DEPTH-1 and out-of-range handling.
    fetch(1'b0, 4'h6, 1'b1, 1'b1, 16'h6666, 4'h6, 1'b0);
    cyc();
    fetch(1'b1, 4'h0, 1'b1, 1'b1, 16'h7777, 4'h7, 1'b0);
    cyc();
    fetch(1'b1, 4'h0, 1'b1, 1'b1, 16'h0234, 4'h0, 1'b0);
    cyc();
    fetch(1'b0, 4'h9, 1'b1, 1'b1, NOP, 4'h9, 1'b1);
    cyc();
    fetch(1'b1, 4'h0, 1'b1, 1'b1, 16'h0234, 4'h0, 1'b0);
    cyc();
    drain();
    load(4'h9, 16'h9999, 1'b0, 1'b1);
    load(4'h8, 16'h8888, 1'b0, 1'b1);
    fetch(1'b0, 4'h0, 1'b1, 1'b1, 16'h0234, 4'h0, 1'b0);
    cyc();
    drain();

    // Async reset while FULL: the held word is dropped and never consumed.
    fetch(1'b0, 4'h1, 1'b0, 1'b1, 16'h0, 4'h0, 1'b0);
    void'(q.pop_back());
    cyc();
    fetch_req = 1'b0;
    chk("full_before_rst", {31'h0, inst_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("async_rst_out",   {16'h0, inst_out},   32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    fetch(1'b1, 4'h5, 1'b1, 1'b1, 16'h0234, 4'h0, 1'b0);
    cyc();
    drain();

    chk("scoreboard_empty", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
